// File: rtl/ft_recovery_ctrl.sv
// Checkpoint/rollback sequencer for a dual-core lockstep pair: periodic register-file
// checkpoints, halt/drain/restore/restart on a lockstep mismatch, fatal stop on repeated failures.
module ft_recovery_ctrl #(
  parameter int          CKPT_INTERVAL = 64,
  parameter int          DRAIN_CYCLES  = 4,
  parameter int          MAX_RETRIES   = 3,
  parameter logic [31:0] BOOT_ADDR     = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        error_i,
  input  logic        instr_retired_i,
  input  logic [31:0] pc_retired_i,
  output logic        core_halt_o,
  output logic        rf_ckpt_o,
  output logic        rf_restore_o,
  output logic        core_reset_o,
  output logic [31:0] boot_addr_o,
  output logic        recovering_o,
  output logic        fatal_o,
  output logic [15:0] error_count_o
);

  localparam int CW = $clog2(CKPT_INTERVAL + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_RESTORE = 3'd2,
    ST_RESTART = 3'd3,
    ST_FATAL   = 3'd4
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   instr_cnt_q;
  logic [DW-1:0]   drain_cnt_q;
  logic [RW-1:0]   retry_cnt_q;
  logic [15:0]     error_count_q;
  logic [31:0]     boot_addr_q;
  logic            core_halt_q;
  logic            rf_ckpt_q;
  logic            rf_restore_q;
  logic            core_reset_q;
  logic            recovering_q;
  logic            fatal_q;

  logic            ckpt_hit_d;
  logic [15:0]     error_count_d;

  always_comb begin
    ckpt_hit_d    = instr_retired_i && (instr_cnt_q == CW'(CKPT_INTERVAL - 1));
    error_count_d = (error_count_q == 16'hFFFF) ? error_count_q : error_count_q + 16'd1;
  end

  // Pulses default low every cycle so a reset or state change never leaves one stretched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      instr_cnt_q   <= '0;
      drain_cnt_q   <= '0;
      retry_cnt_q   <= '0;
      error_count_q <= '0;
      boot_addr_q   <= BOOT_ADDR;
      core_halt_q   <= 1'b0;
      rf_ckpt_q     <= 1'b0;
      rf_restore_q  <= 1'b0;
      core_reset_q  <= 1'b0;
      recovering_q  <= 1'b0;
      fatal_q       <= 1'b0;
    end else begin
      rf_ckpt_q    <= 1'b0;
      rf_restore_q <= 1'b0;
      core_reset_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (enable_i) begin
            if (error_i) begin
              core_halt_q  <= 1'b1;
              recovering_q <= 1'b1;
              if (retry_cnt_q == RW'(MAX_RETRIES)) begin
                state_q <= ST_FATAL;
                fatal_q <= 1'b1;
              end else begin
                state_q       <= ST_DRAIN;
                drain_cnt_q   <= '0;
                retry_cnt_q   <= retry_cnt_q + RW'(1);
                error_count_q <= error_count_d;
              end
            end else if (ckpt_hit_d) begin
              // Restart point is the instruction after the one that closed the interval.
              rf_ckpt_q   <= 1'b1;
              boot_addr_q <= pc_retired_i + 32'd4;
              instr_cnt_q <= '0;
              retry_cnt_q <= '0;
            end else if (instr_retired_i) begin
              instr_cnt_q <= instr_cnt_q + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
            state_q      <= ST_RESTORE;
            rf_restore_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DW'(1);
          end
        end
        ST_RESTORE: begin
          state_q      <= ST_RESTART;
          core_reset_q <= 1'b1;
          instr_cnt_q  <= '0;
        end
        ST_RESTART: begin
          state_q      <= ST_RUN;
          core_halt_q  <= 1'b0;
          recovering_q <= 1'b0;
        end
        ST_FATAL: begin
          core_halt_q  <= 1'b1;
          recovering_q <= 1'b1;
          fatal_q      <= 1'b1;
        end
        default: begin
          state_q      <= ST_FATAL;
          core_halt_q  <= 1'b1;
          recovering_q <= 1'b1;
          fatal_q      <= 1'b1;
        end
      endcase
    end
  end

  assign core_halt_o   = core_halt_q;
  assign rf_ckpt_o     = rf_ckpt_q;
  assign rf_restore_o  = rf_restore_q;
  assign core_reset_o  = core_reset_q;
  assign boot_addr_o   = boot_addr_q;
  assign recovering_o  = recovering_q;
  assign fatal_o       = fatal_q;
  assign error_count_o = error_count_q;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Bench for ft_recovery_ctrl: directed scenarios, a vector table for one recovery
// sequence, and random traffic against a timeline-based reference model.
module tb_ft_recovery_ctrl;

  localparam int CK = 64;
  localparam int D  = 4;
  localparam int MR = 3;

  logic        clk = 1'b0;
  logic        rst, en, err, ret;
  logic [31:0] pc;
  logic        halt, ckpt, restore, creset, recov, fatal;
  logic [31:0] boot;
  logic [15:0] errcnt;

  int total = 0;
  int bad   = 0;
  int n_ckpt, n_restore, n_reset;

  // reference model: recovery is a position on a timeline counted from the error edge
  int          m_cnt, m_retry, m_pos;
  logic [31:0] m_boot;
  logic [15:0] m_errs;
  bit          m_fatal, m_ckpt;

  typedef struct {
    bit          err;
    bit          ret;
    bit          h, rs, rr, rc, f;
    logic [15:0] ec;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  ft_recovery_ctrl dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .error_i(err),
    .instr_retired_i(ret), .pc_retired_i(pc),
    .core_halt_o(halt), .rf_ckpt_o(ckpt), .rf_restore_o(restore),
    .core_reset_o(creset), .boot_addr_o(boot), .recovering_o(recov),
    .fatal_o(fatal), .error_count_o(errcnt)
  );

  task automatic model_edge();
    if (rst) begin
      m_cnt = 0; m_retry = 0; m_pos = 0; m_boot = 32'h80; m_errs = 0;
      m_fatal = 0; m_ckpt = 0;
    end else begin
      m_ckpt = 0;
      if (m_fatal) begin
      end else if (m_pos > 0) begin
        m_pos++;
        if (m_pos == D + 2) m_cnt = 0;
        if (m_pos == D + 3) m_pos = 0;
      end else if (en) begin
        if (err) begin
          if (m_retry == MR) m_fatal = 1;
          else begin
            m_retry++;
            if (m_errs != 16'hFFFF) m_errs++;
            m_pos = 1;
          end
        end else if (ret) begin
          m_cnt++;
          if (m_cnt == CK) begin
            m_ckpt = 1; m_boot = pc + 32'd4; m_cnt = 0; m_retry = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit er, input bit rt, input logic [31:0] p);
    logic [53:0] got, exp;
    bit mh;
    rst = r; en = e; err = er; ret = rt; pc = p;
    model_edge();
    @(posedge clk); #1;
    mh  = m_fatal || (m_pos > 0);
    got = {halt, ckpt, restore, creset, recov, fatal, boot, errcnt};
    exp = {mh, m_ckpt, (m_pos == D + 1), (m_pos == D + 2), mh, m_fatal, m_boot, m_errs};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL model got=%h exp=%h t=%0t", got, exp, $time);
    end
    n_ckpt += int'(ckpt); n_restore += int'(restore); n_reset += int'(creset);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 32'h0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 32'h0);
    cycle(1, 0, 0, 0, 32'h0);
    n_ckpt = 0; n_restore = 0; n_reset = 0;
  endtask

  task automatic retires(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 1, base + 32'(4 * i));
  endtask

  initial begin
    rst = 1; en = 0; err = 0; ret = 0; pc = 0;
    n_ckpt = 0; n_restore = 0; n_reset = 0;
    vecs[0] = '{1, 0, 1, 0, 0, 0, 0, 16'd1};
    vecs[1] = '{0, 1, 1, 0, 0, 0, 0, 16'd1};
    vecs[2] = '{1, 0, 1, 0, 0, 0, 0, 16'd1};
    vecs[3] = '{0, 0, 1, 0, 0, 0, 0, 16'd1};
    vecs[4] = '{0, 0, 1, 0, 1, 0, 0, 16'd1};
    vecs[5] = '{0, 0, 1, 0, 0, 1, 0, 16'd1};
    vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 16'd1};

    // reset values
    do_reset();
    chk("rst_bits", {26'd0, halt, ckpt, restore, creset, recov, fatal}, 32'd0);
    chk("rst_boot", boot, 32'h80);
    chk("rst_errcnt", {16'd0, errcnt}, 32'd0);

    // test 1: 64 retires -> one checkpoint
    retires(CK - 1, 32'h100);
    chk("ckpt_early", n_ckpt, 0);
    cycle(0, 1, 0, 1, 32'h1FC);
    chk("ckpt_pulse", {31'd0, ckpt}, 32'd1);
    chk("ckpt_boot", boot, 32'h200);
    idle(2);
    chk("ckpt_once", n_ckpt, 1);

    // test 2: table-driven recovery sequence, error ignored mid-drain
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, vecs[i].err, vecs[i].ret, 32'h500);
      chk($sformatf("vec%0d", i),
          {11'd0, halt, ckpt, restore, creset, fatal, errcnt},
          {11'd0, vecs[i].h, vecs[i].rs, vecs[i].rr, vecs[i].rc, vecs[i].f, vecs[i].ec});
      if (i == 5) chk("restart_boot", boot, 32'h200);
    end

    // test 3: four errors without retires -> fatal
    do_reset();
    for (int e = 0; e < 3; e++) begin
      cycle(0, 1, 1, 0, 32'h0);
      idle(D + 2);
    end
    chk("t3_restores", n_restore, 3);
    chk("t3_resets", n_reset, 3);
    cycle(0, 1, 1, 0, 32'h0);
    chk("t3_fatal", {30'd0, fatal, halt}, 32'd3);
    cycle(0, 1, 1, 1, 32'h0);
    cycle(0, 0, 0, 1, 32'h0);
    idle(5);
    chk("t3_sticky", {29'd0, fatal, halt, recov}, 32'd7);
    chk("t3_errcnt", {16'd0, errcnt}, 32'd3);

    // test 4: error on the checkpoint retire wins
    do_reset();
    retires(CK - 1, 32'h100);
    cycle(0, 1, 1, 1, 32'h300);
    chk("t4_no_ckpt", {31'd0, ckpt}, 32'd0);
    chk("t4_boot", boot, 32'h80);
    idle(D + 2);
    chk("t4_recovered", {30'd0, n_restore == 1, n_reset == 1}, 32'd3);

    // test 5: error held through drain, then retriggers in RUN
    do_reset();
    cycle(0, 1, 1, 0, 32'h0);
    for (int i = 0; i < D + 2; i++) cycle(0, 1, 1, 0, 32'h0);
    chk("t5_once", {16'd0, errcnt}, 32'd1);
    chk("t5_resumed", {31'd0, halt}, 32'd0);
    cycle(0, 1, 1, 0, 32'h0);
    chk("t5_retrig", {16'd0, errcnt}, 32'd2);
    idle(D + 2);
    cycle(0, 1, 1, 0, 32'h0);
    idle(D + 2);
    chk("t5_third", {16'd0, errcnt}, 32'd3);
    cycle(0, 1, 1, 0, 32'h0);
    chk("t5_fatal", {31'd0, fatal}, 32'd1);

    // test 6: reset during drain cycle 2
    do_reset();
    retires(CK, 32'h100);
    cycle(0, 1, 1, 0, 32'h0);
    cycle(0, 1, 0, 0, 32'h0);
    cycle(1, 1, 0, 0, 32'h0);
    chk("t6_bits", {26'd0, halt, ckpt, restore, creset, recov, fatal}, 32'd0);
    chk("t6_boot", boot, 32'h80);
    idle(D + 3);
    chk("t6_no_restore", n_restore, 0);

    // boot address wrap
    do_reset();
    retires(CK - 1, 32'h0);
    cycle(0, 1, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_boot", boot, 32'h0);

    // enable low: retires held, error ignored, in-flight recovery completes
    do_reset();
    retires(CK - 1, 32'h100);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1, 32'h700);
    chk("dis_ignored", {30'd0, halt, ckpt}, 32'd0);
    cycle(0, 1, 0, 1, 32'h800);
    chk("dis_ckpt", boot, 32'h804);
    cycle(0, 1, 1, 0, 32'h0);
    for (int i = 0; i < D + 2; i++) cycle(0, 0, 0, 0, 32'h0);
    chk("dis_complete", {30'd0, n_reset == 1, halt}, 32'd2);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            $urandom() & 32'hFFFF_FFFC);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
